// File: rtl/sd_bmp_loader.sv
// SD-to-SDRAM BMP loader: sectors of one image per request, header stripped, pixels written as RGB565; writes trail their SD word by 1 cycle.
// No backpressure on SD words or SDRAM strobes. Define SD_BMP_AUTOLOAD_EN to boot-load every slot after reset.
module sd_bmp_loader #(
   parameter int IMG_NUM    = 8,
   parameter int IDX_W      = 3,
   parameter int ADDR_W     = 24,
   parameter int IMG_STRIDE = 307200,
   parameter int HEAD_BYTES = 54
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [32*IMG_NUM-1:0]   sec_table,
   input  logic [15:0]             sd_sec_num,
   input  logic [ADDR_W-1:0]       pix_max,
   input  logic                    bpp16,
   input  logic                    load_req,
   input  logic [IDX_W-1:0]        load_idx,
   input  logic                    rd_busy,
   input  logic                    sd_rd_val_en,
   input  logic [15:0]             sd_rd_val_data,
   output logic                    rd_start_en,
   output logic [31:0]             rd_sec_addr,
   output logic                    sdram_wr_en,
   output logic [ADDR_W-1:0]       sdram_wr_addr,
   output logic [15:0]             sdram_wr_data,
   output logic                    busy,
   output logic                    load_done,
   output logic                    boot_done
);

   localparam int HEAD_WORDS = HEAD_BYTES / 2;

   typedef enum logic [1:0] {IDLE, START, WAIT_SEC, FINISH} rd_state_e;
   typedef enum logic [1:0] {HEAD, DATA, DRAIN} px_state_e;

   rd_state_e         rd_state_q;
   px_state_e         px_state_q;
   logic              busy_d0_q, busy_d1_q;
   logic [IDX_W-1:0]  idx_q;
   logic              bpp16_q;
   logic [15:0]       sec_num_q, sec_cnt_q, sec_cnt_d;
   logic              rd_start_en_q, busy_q, load_done_q, boot_done_q;
   logic [31:0]       rd_sec_addr_q;
   logic [15:0]       hw_cnt_q;
   logic [1:0]        phase_q;
   logic [15:0]       w0_q, w1_q;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d, slot_base;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;

   logic              req_vld, req_ok, sec_fall, word_take, px_vld;
   logic [IDX_W-1:0]  req_idx;
   logic [15:0]       px_dat;

   function automatic logic [15:0] to565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

`ifdef SD_BMP_AUTOLOAD_EN
   logic [IDX_W-1:0] auto_idx_q;
   // Until every slot has been boot-loaded the request comes from the slot walker.
   assign req_vld = boot_done_q ? load_req : 1'b1;
   assign req_idx = boot_done_q ? load_idx : auto_idx_q;
`else
   assign req_vld = load_req;
   assign req_idx = load_idx;
`endif

   assign req_ok    = req_vld && (32'(req_idx) < IMG_NUM);
   assign sec_fall  = busy_d1_q & ~busy_d0_q;
   assign sec_cnt_d = sec_cnt_q + 16'd1;
   assign pix_cnt_d = pix_cnt_q + ADDR_W'(1);
   assign slot_base = ADDR_W'(IMG_STRIDE) * ADDR_W'(idx_q);
   assign word_take = sd_rd_val_en && busy_q && (rd_state_q != FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q    <= IDLE;
         busy_d0_q     <= 1'b0;
         busy_d1_q     <= 1'b0;
         idx_q         <= '0;
         bpp16_q       <= 1'b0;
         sec_num_q     <= '0;
         sec_cnt_q     <= '0;
         rd_sec_addr_q <= '0;
         rd_start_en_q <= 1'b0;
         busy_q        <= 1'b0;
         load_done_q   <= 1'b0;
         boot_done_q   <= 1'b0;
`ifdef SD_BMP_AUTOLOAD_EN
         auto_idx_q    <= '0;
`endif
      end else begin
         busy_d0_q     <= rd_busy;
         busy_d1_q     <= busy_d0_q;
         rd_start_en_q <= 1'b0;
         load_done_q   <= 1'b0;
`ifndef SD_BMP_AUTOLOAD_EN
         boot_done_q   <= 1'b1;
`endif
         case (rd_state_q)
            IDLE: begin
               if (req_ok) begin
                  idx_q         <= req_idx;
                  bpp16_q       <= bpp16;
                  sec_num_q     <= sd_sec_num;
                  sec_cnt_q     <= '0;
                  rd_sec_addr_q <= sec_table[req_idx*32 +: 32];
                  busy_q        <= 1'b1;
                  if (sd_sec_num == 16'd0) rd_state_q <= FINISH;
                  else                     rd_state_q <= START;
               end
            end
            START: begin
               rd_start_en_q <= 1'b1;
               rd_state_q    <= WAIT_SEC;
            end
            WAIT_SEC: begin
               if (sec_fall) begin
                  rd_sec_addr_q <= rd_sec_addr_q + 32'd1;
                  sec_cnt_q     <= sec_cnt_d;
                  if (sec_cnt_d == sec_num_q) rd_state_q <= FINISH;
                  else                        rd_state_q <= START;
               end
            end
            FINISH: begin
               load_done_q <= 1'b1;
               busy_q      <= 1'b0;
               rd_state_q  <= IDLE;
`ifdef SD_BMP_AUTOLOAD_EN
               if (!boot_done_q) begin
                  if (auto_idx_q == IDX_W'(IMG_NUM - 1)) boot_done_q <= 1'b1;
                  else                                    auto_idx_q  <= auto_idx_q + 1'b1;
               end
`endif
            end
            default: rd_state_q <= IDLE;
         endcase
      end
   end

   // 24 bpp: three words carry two BGR pixels; the pixel completes on w1 and on w2.
   always_comb begin
      px_vld = 1'b0;
      px_dat = {sd_rd_val_data[7:0], sd_rd_val_data[15:8]};
      if (word_take && px_state_q == DATA) begin
         if (bpp16_q) begin
            px_vld = 1'b1;
         end else if (phase_q == 2'd1) begin
            px_vld = 1'b1;
            px_dat = to565({sd_rd_val_data[15:8], w0_q[7:0], w0_q[15:8]});
         end else if (phase_q == 2'd2) begin
            px_vld = 1'b1;
            px_dat = to565({sd_rd_val_data[7:0], sd_rd_val_data[15:8], w1_q[7:0]});
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_state_q <= HEAD;
         hw_cnt_q   <= '0;
         phase_q    <= '0;
         w0_q       <= '0;
         w1_q       <= '0;
         pix_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (rd_state_q == FINISH) begin
            px_state_q <= HEAD;
            hw_cnt_q   <= '0;
            phase_q    <= '0;
            pix_cnt_q  <= '0;
         end else if (word_take) begin
            case (px_state_q)
               HEAD: begin
                  if (hw_cnt_q == 16'(HEAD_WORDS - 1)) begin
                     hw_cnt_q <= '0;
                     if (pix_max == '0) px_state_q <= DRAIN;
                     else               px_state_q <= DATA;
                  end else begin
                     hw_cnt_q <= hw_cnt_q + 16'd1;
                  end
               end
               DATA: begin
                  if (!bpp16_q) begin
                     if (phase_q == 2'd0) w0_q <= sd_rd_val_data;
                     if (phase_q == 2'd1) w1_q <= sd_rd_val_data;
                     phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                  end
                  if (px_vld) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= slot_base + pix_cnt_q;
                     wr_data_q <= px_dat;
                     pix_cnt_q <= pix_cnt_d;
                     if (pix_cnt_d >= pix_max) px_state_q <= DRAIN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rd_start_en   = rd_start_en_q;
   assign rd_sec_addr   = rd_sec_addr_q;
   assign sdram_wr_en   = wr_en_q;
   assign sdram_wr_addr = wr_addr_q;
   assign sdram_wr_data = wr_data_q;
   assign busy          = busy_q;
   assign load_done     = load_done_q;
   assign boot_done     = boot_done_q;

endmodule

// File: tb/tb_sd_bmp_loader.sv
// Bench for sd_bmp_loader: an SD sector responder feeds image words, and a byte-stream model of the
// BMP pixel layout predicts every SDRAM write, sector address and completion pulse.
module tb_sd_bmp_loader;
   localparam int IMG_NUM = 8;
   localparam int IDX_W   = 4;
   localparam int ADDR_W  = 24;
   localparam int STRIDE  = 307200;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [32*IMG_NUM-1:0] sec_table;
   logic [15:0]           sd_sec_num;
   logic [ADDR_W-1:0]     pix_max;
   logic                  bpp16, load_req;
   logic [IDX_W-1:0]      load_idx;
   logic                  rd_busy, sd_rd_val_en;
   logic [15:0]           sd_rd_val_data;
   logic                  rd_start_en, sdram_wr_en, busy, load_done, boot_done;
   logic [31:0]           rd_sec_addr;
   logic [ADDR_W-1:0]     sdram_wr_addr;
   logic [15:0]           sdram_wr_data;

   always #5 clk = ~clk;

   sd_bmp_loader #(.IMG_NUM(IMG_NUM), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
                   .IMG_STRIDE(STRIDE), .HEAD_BYTES(54)) dut (
      .clk(clk), .rst_n(rst_n), .sec_table(sec_table), .sd_sec_num(sd_sec_num),
      .pix_max(pix_max), .bpp16(bpp16), .load_req(load_req), .load_idx(load_idx),
      .rd_busy(rd_busy), .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
      .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .sdram_wr_en(sdram_wr_en),
      .sdram_wr_addr(sdram_wr_addr), .sdram_wr_data(sdram_wr_data), .busy(busy),
      .load_done(load_done), .boot_done(boot_done));

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Image words for the current load, owned by the main sequence and read by the responder.
   logic [15:0] mem [0:4095];
   int          nwords = 0;
   int          wps = 32;
   logic [31:0] tbl [IMG_NUM];
   logic [15:0] force_q [$];
   logic [39:0] exp_q [$];
   int          cur_idx, cur_nsec, gbase, sbase, dbase;

   logic [39:0] got_q [$];
   logic [31:0] start_q [$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (sdram_wr_en) got_q.push_back({sdram_wr_addr, sdram_wr_data});
      if (rd_start_en) start_q.push_back(rd_sec_addr);
      if (load_done) done_cnt++;
   end

   // SD read controller: each start pulse serves one sector of wps words with random gaps.
   int ptr;
   initial begin
      rd_busy = 1'b0; sd_rd_val_en = 1'b0; sd_rd_val_data = 16'h0; ptr = 0;
      forever begin
         @(negedge clk);
         if (!busy) ptr = 0;
         if (rst_n && rd_start_en) begin
            rd_busy = 1'b1;
            for (int w = 0; w < wps && rst_n; w++) begin
               sd_rd_val_en = 1'b0;
               if ($urandom_range(0, 3) == 0) @(negedge clk);
               if (!rst_n) break;
               sd_rd_val_en   = 1'b1;
               sd_rd_val_data = (ptr < nwords) ? mem[ptr] : 16'h0;
               ptr++;
               @(negedge clk);
            end
            sd_rd_val_en = 1'b0;
            if (rst_n) repeat (2) @(negedge clk);
            rd_busy = 1'b0;
         end
      end
   end

   // Reference: the image as a byte stream, 54 header bytes dropped, BGR triplets or
   // little-endian 16-bit pixels, at most pmax of them, addressed from the slot base.
   task automatic build_model(input int idx, input bit b16, input int pmax);
      byte unsigned bs [$];
      int npx, r, g, b, pix;
      logic [31:0] addr;
      exp_q.delete();
      for (int i = 0; i < nwords; i++) begin
         bs.push_back(mem[i][15:8]);
         bs.push_back(mem[i][7:0]);
      end
      if (bs.size() >= 54) bs = bs[54:$];
      else bs.delete();
      npx = b16 ? bs.size() / 2 : bs.size() / 3;
      if (npx > pmax) npx = pmax;
      for (int k = 0; k < npx; k++) begin
         if (b16) pix = bs[2*k+1] * 256 + bs[2*k];
         else begin
            b = bs[3*k]; g = bs[3*k+1]; r = bs[3*k+2];
            pix = (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
         end
         addr = (idx * STRIDE + k) % (1 << ADDR_W);
         exp_q.push_back({addr[23:0], 16'(pix)});
      end
   endtask

   task automatic start_load(input int idx, input bit b16, input int nsec, input int pmax, input int wpsv);
      @(negedge clk);
      cur_idx = idx; cur_nsec = nsec; wps = wpsv; nwords = nsec * wpsv;
      for (int i = 0; i < nwords; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < force_q.size() && 27 + i < nwords; i++) mem[27+i] = force_q[i];
      build_model(idx, b16, pmax);
      gbase = got_q.size(); sbase = start_q.size(); dbase = done_cnt;
      sd_sec_num = 16'(nsec); pix_max = ADDR_W'(pmax); bpp16 = b16;
      load_idx = IDX_W'(idx); load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      bpp16 = ~b16;
      sd_sec_num = 16'(nsec + 5);
      check("busy_after_req", busy, 1'b1);
      check("start_not_yet", rd_start_en, 1'b0);
      @(negedge clk);
      check("start_pulse", rd_start_en, nsec != 0);
      check("first_sec_addr", rd_sec_addr, tbl[idx]);
   endtask

   task automatic finish_load();
      int ns, np;
      for (int c = 0; c < 20000 && done_cnt == dbase; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("load_done_count", done_cnt - dbase, 1);
      ns = start_q.size() - sbase;
      check("sector_count", ns, cur_nsec);
      for (int s = 0; s < ns && s < cur_nsec; s++)
         check($sformatf("sec_addr%0d", s), start_q[sbase+s], tbl[cur_idx] + 32'(s));
      np = got_q.size() - gbase;
      check("pixel_count", np, exp_q.size());
      for (int k = 0; k < np && k < exp_q.size(); k++)
         check($sformatf("pixel%0d", k), got_q[gbase+k], exp_q[k]);
      check("end_sec_addr", rd_sec_addr, tbl[cur_idx] + 32'(cur_nsec));
      check("busy_end", busy, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_start"}, rd_start_en, 1'b0);
      check({tag, "_secaddr"}, rd_sec_addr, 32'h0);
      check({tag, "_wr_en"}, sdram_wr_en, 1'b0);
      check({tag, "_wr_addr"}, sdram_wr_addr, '0);
      check({tag, "_wr_data"}, sdram_wr_data, 16'h0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, load_done, 1'b0);
      check({tag, "_boot"}, boot_done, 1'b0);
   endtask

   initial begin
      int s0, d0;
      logic [31:0] a0;
      rst_n = 1'b0; load_req = 1'b0; load_idx = '0; bpp16 = 1'b0;
      sd_sec_num = 16'd1; pix_max = ADDR_W'(1);
      for (int i = 0; i < IMG_NUM; i++) tbl[i] = $urandom;
      tbl[1] = 32'd46720;
      for (int i = 0; i < IMG_NUM; i++) sec_table[32*i +: 32] = tbl[i];

      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(negedge clk) rst_n = 1'b1;
`ifdef SD_BMP_AUTOLOAD_EN
      wps = 8;
      for (int c = 0; c < 20000 && !boot_done; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("boot_loads", done_cnt, IMG_NUM);
      check("boot_starts", start_q.size(), IMG_NUM);
      for (int i = 0; i < IMG_NUM && i < start_q.size(); i++)
         check($sformatf("boot_slot%0d", i), start_q[i], tbl[i]);
      check("boot_done_final", boot_done, 1'b1);
`else
      repeat (2) @(negedge clk);
      check("boot_done_default", boot_done, 1'b1);
`endif

      // 24 bpp across a sector boundary, slot 1
      force_q = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC};
      start_load(1, 1'b0, 2, 4, 32);
      finish_load();
      check("t24_px0", got_q[gbase], {24'd307200, 16'h3102});
      check("t24_px1", got_q[gbase+1], {24'd307201, 16'h62A8});

      // 16 bpp, slot 2
      force_q = '{16'h34F8};
      start_load(2, 1'b1, 1, 5, 40);
      finish_load();
      check("t16_px0", got_q[gbase], {24'd614400, 16'hF834});

      // pixel budget exhausted in the first of three sectors
      force_q.delete();
      start_load(3, 1'b0, 3, 3, 32);
      finish_load();

      // request while busy is dropped
      start_load(5, 1'b0, 2, 10, 40);
      for (int c = 0; c < 2000 && start_q.size() == sbase; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      load_idx = 4'd6; load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
      finish_load();
      s0 = start_q.size();
      repeat (20) @(negedge clk);
      check("busy_req_not_queued", start_q.size(), s0);

      // out-of-range slot index is ignored
      a0 = rd_sec_addr; d0 = done_cnt;
      load_idx = 4'd9; load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
      repeat (10) @(negedge clk);
      check("bad_idx_busy", busy, 1'b0);
      check("bad_idx_starts", start_q.size(), s0);
      check("bad_idx_secaddr", rd_sec_addr, a0);
      check("bad_idx_done", done_cnt, d0);

      // zero sectors: completion without any read
      start_load(0, 1'b0, 0, 4, 32);
      finish_load();

      // reset in the middle of a sector
      start_load(4, 1'b0, 2, 50, 64);
      repeat (40) @(negedge clk);
      d0 = done_cnt;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_outputs_zero("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midreset_no_done", done_cnt, d0);
      force_q.delete();
      start_load(4, 1'b1, 2, 30, 48);
      finish_load();

      for (int it = 0; it < 6; it++) begin
         start_load($urandom_range(0, IMG_NUM - 1), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 3), $urandom_range(1, 40), $urandom_range(28, 48));
         finish_load();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
